// File: rtl/carb_dispatch_sched_pkg.sv
// Shared types for the clause arbiter: literal/clause encodings and the round FSM states.
package carb_dispatch_sched_pkg;

  localparam int LIT_W       = 11;
  localparam int CLA_LENGTH  = 3;
  localparam int NUM_ENG_DEF = 4;

  // A zero literal marks an empty clause slot.
  typedef logic signed [LIT_W-1:0] lit_t;
  typedef lit_t [CLA_LENGTH-1:0]    cla_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_CONFLICT
  } carb_state_t;

endpackage

// File: rtl/carb_fifo.sv
// Clause FIFO with extra-MSB wrap pointers; flush wins over push and pop in the same cycle.
module carb_fifo
  import carb_dispatch_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  cla_t i_data,
  input  logic i_pop,
  input  logic i_flush,
  output cla_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_head;
  logic [AW:0] r_tail;
  cla_t        r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_head == r_tail);
  assign o_full    = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_head[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + PTR_ONE;
      if (w_pop_ok)  r_head <= r_head + PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_tail[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/carb_dispatch_sched.sv
// Clause arbiter: buffers memory clauses, dispatches round-robin to engines, broadcasts unit clauses.
// Optional stall counter output enabled by defining CARB_STALL_CNT_EN.
module carb_dispatch_sched
  import carb_dispatch_sched_pkg::*;
#(
  parameter int NUM_ENG  = NUM_ENG_DEF,
  parameter int IN_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem2carb_start,
  input  logic               mem2carb_finish,
  input  cla_t               mem2carb_clause,
  output logic               carb2mem_ready,
  input  logic               mem2carb_uc_valid,
  input  lit_t               mem2carb_uc,
  output logic               carb2mem_uc_ready,
  output cla_t               eng_cla,
  output logic [NUM_ENG-1:0] eng_cla_valid,
  input  logic [NUM_ENG-1:0] eng_cla_ready,
  output lit_t               eng_uc,
  output logic [NUM_ENG-1:0] eng_uc_valid,
  input  logic [NUM_ENG-1:0] eng_uc_ready,
  input  logic [NUM_ENG-1:0] eng_conflict,
  output logic               conflict,
  output logic               done,
  output logic               carb_empty
`ifdef CARB_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  carb_state_t        r_state;
  carb_state_t        w_state_nxt;
  logic [PW-1:0]      r_rr_ptr;
  logic [NUM_ENG-1:0] r_uc_mask;
  lit_t               r_uc;

  cla_t               w_fifo_data;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_conf_in;
  logic               w_dispatch_ok;
  logic               w_uc_acc;
  logic [NUM_ENG-1:0] w_sel;
  logic [PW-1:0]      w_sel_idx;
  logic               w_sel_found;
  logic [PW-1:0]      w_rr_nxt;

  assign w_conf_in     = |eng_conflict;
  assign w_flush       = w_conf_in || (r_state == ST_CONFLICT);
  assign carb2mem_ready = !w_fifo_full && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_push        = mem2carb_start && carb2mem_ready;
  assign w_dispatch_ok = !w_fifo_empty && (r_state != ST_CONFLICT);
  assign w_pop         = w_dispatch_ok && w_sel_found;

  carb_fifo #(
    .DEPTH (IN_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .i_push  (w_push),
    .i_data  (mem2carb_clause),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // First ready engine at or after the round-robin pointer, wrapping around.
  always_comb begin
    int v_idx;
    w_sel       = '0;
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    v_idx       = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_ENG;
      if (!w_sel_found && eng_cla_ready[v_idx]) begin
        w_sel_found  = 1'b1;
        w_sel_idx    = PW'(v_idx);
        w_sel[v_idx] = 1'b1;
      end
    end
  end

  assign w_rr_nxt      = (int'(w_sel_idx) == NUM_ENG - 1) ? '0 : w_sel_idx + PW'(1);
  assign eng_cla       = w_fifo_data;
  assign eng_cla_valid = w_dispatch_ok ? w_sel : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_pop) begin
      r_rr_ptr <= w_rr_nxt;
    end
  end

  assign carb2mem_uc_ready = (r_uc_mask == '0) && (r_state != ST_CONFLICT);
  assign w_uc_acc          = mem2carb_uc_valid && carb2mem_uc_ready;
  assign eng_uc            = r_uc;
  assign eng_uc_valid      = (r_state == ST_CONFLICT) ? '0 : r_uc_mask;

  // Each engine drops out of the pending mask once it has taken the broadcast.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_uc_mask <= '0;
    end else if (w_flush) begin
      r_uc_mask <= '0;
    end else if (w_uc_acc) begin
      r_uc_mask <= '1;
    end else begin
      r_uc_mask <= r_uc_mask & ~(eng_uc_valid & eng_uc_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (w_uc_acc) r_uc <= mem2carb_uc;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = mem2carb_finish ? ST_DRAIN : ST_LOAD;
      end
      ST_LOAD: begin
        if (mem2carb_finish && (!mem2carb_start || w_push)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_fifo_empty && (r_uc_mask == '0)) w_state_nxt = ST_DONE;
      end
      ST_DONE:     w_state_nxt = ST_IDLE;
      ST_CONFLICT: w_state_nxt = ST_CONFLICT;
      default:     w_state_nxt = ST_IDLE;
    endcase
    // A conflict pre-empts every other transition, including DRAIN -> DONE.
    if (w_conf_in) w_state_nxt = ST_CONFLICT;
  end

  assign conflict   = (r_state == ST_CONFLICT);
  assign done       = (r_state == ST_DONE);
  assign carb_empty = w_fifo_empty && (r_uc_mask == '0) &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_CONFLICT));

`ifdef CARB_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_fifo_empty && !(|eng_cla_ready) && (r_state != ST_CONFLICT)) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_carb_dispatch_sched.sv
// Scoreboard bench for carb_dispatch_sched: directed rounds, UC broadcast, backpressure, conflict, reset.
module tb_carb_dispatch_sched;
  import carb_dispatch_sched_pkg::*;

  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem2carb_start;
  logic          mem2carb_finish;
  cla_t          mem2carb_clause;
  logic          carb2mem_ready;
  logic          mem2carb_uc_valid;
  lit_t          mem2carb_uc;
  logic          carb2mem_uc_ready;
  cla_t          eng_cla;
  logic [NE-1:0] eng_cla_valid;
  logic [NE-1:0] eng_cla_ready;
  lit_t          eng_uc;
  logic [NE-1:0] eng_uc_valid;
  logic [NE-1:0] eng_uc_ready;
  logic [NE-1:0] eng_conflict;
  logic          conflict;
  logic          done;
  logic          carb_empty;

  typedef struct packed {
    cla_t          cla;
    logic [NE-1:0] oh;
  } exp_t;

  exp_t q_exp[$];
  int   n_err = 0;
  int   n_chk = 0;
  logic sim_end = 1'b0;

  always #5 clk = ~clk;

  carb_dispatch_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem2carb_start    (mem2carb_start),
    .mem2carb_finish   (mem2carb_finish),
    .mem2carb_clause   (mem2carb_clause),
    .carb2mem_ready    (carb2mem_ready),
    .mem2carb_uc_valid (mem2carb_uc_valid),
    .mem2carb_uc       (mem2carb_uc),
    .carb2mem_uc_ready (carb2mem_uc_ready),
    .eng_cla           (eng_cla),
    .eng_cla_valid     (eng_cla_valid),
    .eng_cla_ready     (eng_cla_ready),
    .eng_uc            (eng_uc),
    .eng_uc_valid      (eng_uc_valid),
    .eng_uc_ready      (eng_uc_ready),
    .eng_conflict      (eng_conflict),
    .conflict          (conflict),
    .done              (done),
    .carb_empty        (carb_empty)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic cla_t mk(input int a, input int b, input int c);
    cla_t r;
    r[0] = lit_t'(a);
    r[1] = lit_t'(b);
    r[2] = lit_t'(c);
    return r;
  endfunction

  // eng < 0: clause is expected to be discarded (conflict flush or reset).
  task automatic push_cla(input cla_t c, input logic fin, input int eng);
    exp_t e;
    mem2carb_start  = 1'b1;
    mem2carb_clause = c;
    mem2carb_finish = fin;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (carb2mem_ready) begin
        if (eng >= 0) begin
          e.cla = c;
          e.oh = '0;
          e.oh[eng] = 1'b1;
          q_exp.push_back(e);
        end
        @(posedge clk);
        #1;
        mem2carb_start  = 1'b0;
        mem2carb_finish = 1'b0;
        return;
      end
    end
    n_chk++;
    n_err++;
    $display("FAIL push_timeout: clause %0h never accepted within 20 cycles", c);
    mem2carb_start  = 1'b0;
    mem2carb_finish = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk({nm, "_done_pulses"}, 64'(cnt), 64'd1);
    chk({nm, "_empty_after"}, 64'(carb_empty), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 64'(carb2mem_ready), 64'd1);
    chk({nm, "_uc_ready"}, 64'(carb2mem_uc_ready), 64'd1);
    chk({nm, "_cla_valid"}, 64'(eng_cla_valid), 64'd0);
    chk({nm, "_uc_valid"}, 64'(eng_uc_valid), 64'd0);
    chk({nm, "_conflict"}, 64'(conflict), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_empty"}, 64'(carb_empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      begin : stim
        int dcnt;
        rst_n             = 1'b1;
        mem2carb_start    = 1'b0;
        mem2carb_finish   = 1'b0;
        mem2carb_clause   = '0;
        mem2carb_uc_valid = 1'b0;
        mem2carb_uc       = '0;
        eng_cla_ready     = '0;
        eng_uc_ready      = '0;
        eng_conflict      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_held");
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_released");
        @(posedge clk);
        #1;

        // Round-robin with every engine ready
        eng_cla_ready = 4'b1111;
        push_cla(mk(1, 2, 7), 1'b0, 0);
        push_cla(mk(2, -1, 5), 1'b0, 1);
        push_cla(mk(0, 3, 1), 1'b0, 2);
        push_cla(mk(6, 3, 1), 1'b1, 3);
        wait_done("rr");

        // Engine 1 not ready: it is skipped and the pointer wraps back to 0
        eng_cla_ready = 4'b1101;
        push_cla(mk(1, 1, 1), 1'b0, 0);
        push_cla(mk(2, 2, 2), 1'b0, 2);
        push_cla(mk(3, 3, 3), 1'b1, 3);
        wait_done("skip");
        eng_cla_ready = 4'b1111;
        push_cla(mk(4, -4, 0), 1'b1, 0);
        wait_done("rr_after_skip");

        // Unit-clause broadcast with engine 2 late
        eng_uc_ready      = 4'b1011;
        mem2carb_uc       = lit_t'(-1);
        mem2carb_uc_valid = 1'b1;
        @(negedge clk);
        chk("uc_ready_idle", 64'(carb2mem_uc_ready), 64'd1);
        @(posedge clk);
        #1;
        mem2carb_uc_valid = 1'b0;
        @(negedge clk);
        chk("uc_valid_c1", 64'(eng_uc_valid), 64'hF);
        chk("uc_value", 64'($unsigned(eng_uc)), 64'h7FF);
        chk("uc_ready_c1", 64'(carb2mem_uc_ready), 64'd0);
        chk("uc_empty_c1", 64'(carb_empty), 64'd0);
        for (int c = 2; c <= 5; c++) begin
          @(posedge clk);
          #1;
          if (c == 5) eng_uc_ready = 4'b1111;
          @(negedge clk);
          chk("uc_valid_held", 64'(eng_uc_valid), 64'h4);
          chk("uc_ready_held", 64'(carb2mem_uc_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("uc_valid_clear", 64'(eng_uc_valid), 64'd0);
        chk("uc_ready_back", 64'(carb2mem_uc_ready), 64'd1);
        chk("uc_empty_back", 64'(carb_empty), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: no engine ready, FIFO fills, fifth clause waits
        eng_cla_ready = 4'b0000;
        push_cla(mk(10, 11, 12), 1'b0, 2);
        push_cla(mk(13, 14, 15), 1'b0, 2);
        push_cla(mk(16, 17, 18), 1'b0, 2);
        push_cla(mk(19, 20, 21), 1'b0, 2);
        mem2carb_start  = 1'b1;
        mem2carb_clause = mk(-5, -6, -7);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_ready_full", 64'(carb2mem_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        eng_cla_ready = 4'b0100;
        push_cla(mk(-5, -6, -7), 1'b0, 2);
        mem2carb_finish = 1'b1;
        @(posedge clk);
        #1;
        mem2carb_finish = 1'b0;
        wait_done("bp");

        // Conflict with two clauses queued
        eng_cla_ready = 4'b0000;
        push_cla(mk(7, 8, 9), 1'b0, -1);
        push_cla(mk(9, 8, 7), 1'b0, -1);
        eng_conflict = 4'b1000;
        @(posedge clk);
        #1;
        eng_conflict = 4'b0000;
        @(negedge clk);
        chk("cf_conflict", 64'(conflict), 64'd1);
        chk("cf_empty", 64'(carb_empty), 64'd1);
        chk("cf_ready", 64'(carb2mem_ready), 64'd0);
        chk("cf_uc_ready", 64'(carb2mem_uc_ready), 64'd0);
        chk("cf_cla_valid", 64'(eng_cla_valid), 64'd0);
        eng_cla_ready  = 4'b1111;
        mem2carb_start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("cf_sticky", 64'(conflict), 64'd1);
          if (done) dcnt++;
        end
        chk("cf_no_done", 64'(dcnt), 64'd0);
        chk("cf_no_valid", 64'(eng_cla_valid), 64'd0);
        mem2carb_start = 1'b0;

        // Reset in the middle of a LOAD round
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        eng_cla_ready = 4'b0000;
        push_cla(mk(5, 5, 5), 1'b0, -1);
        push_cla(mk(6, 6, 6), 1'b0, -1);
        #2;
        rst_n = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        eng_cla_ready = 4'b1111;
        push_cla(mk(0, 3, 1), 1'b1, 0);
        wait_done("post_rst");
        sim_end = 1'b1;
      end

      begin : mon
        exp_t e;
        while (!sim_end) begin
          @(negedge clk);
          if (!rst_n && (|(eng_cla_valid & eng_cla_ready))) begin
            if (q_exp.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL dispatch_unexpected: engines %b took %0h, none expected", eng_cla_valid, eng_cla);
            end else begin
              e = q_exp.pop_front();
              chk("dispatch_eng", 64'(eng_cla_valid), 64'(e.oh));
              chk("dispatch_cla", 64'(eng_cla), 64'(e.cla));
            end
          end
        end
      end
    join

    chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
